// File: rtl/clk_enable_divider.sv
// Multi-channel clock-enable divider. Each channel counts clk_in cycles and
// emits a one-cycle enable strobe every De cycles. In toggle mode it also
// drives a 50% square-wave level. No derived clocks are produced; downstream
// logic stays on clk_in and qualifies itself with tick_out.
module clk_enable_divider #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [CHANNELS-1:0] en_in,
    input  logic                cfg_we_in,
    input  logic [CH_W-1:0]     cfg_ch_in,
    input  logic [WIDTH-1:0]    cfg_div_in,
    input  logic                cfg_mode_in,
    input  logic                cfg_now_in,
    input  logic                sync_in,
    output logic [CHANNELS-1:0] tick_out,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pending_out
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] div_act_q, div_act_d;
        logic [WIDTH-1:0] div_pend_q, div_pend_d;
        logic             mode_act_q, mode_act_d;
        logic             mode_pend_q, mode_pend_d;
        logic             pend_q, pend_d;
        logic             level_q, level_d;
        logic             tick_q, tick_d;

        logic             write_hit;
        logic [WIDTH-1:0] last_cnt;
        logic [WIDTH-1:0] apply_div;
        logic             apply_mode;

        // Out-of-range channel numbers never match, so such writes are dropped.
        assign write_hit = cfg_we_in && (cfg_ch_in == CH_W'(gi));

        // Next-state logic: reset handled in the flop block, then
        // sync > immediate write > count/wrap.
        always_comb begin
            cnt_d       = cnt_q;
            div_act_d   = div_act_q;
            div_pend_d  = div_pend_q;
            mode_act_d  = mode_act_q;
            mode_pend_d = mode_pend_q;
            pend_d      = pend_q;
            level_d     = level_q;
            tick_d      = 1'b0;

            // A ratio of 0 behaves like 1, so the terminal count is then 0.
            last_cnt = (div_act_q == '0) ? '0 : div_act_q - WIDTH'(1);

            // Config that takes effect at a wrap or sync: a write arriving on
            // the same edge wins over an older pending one.
            if (write_hit) begin
                apply_div  = cfg_div_in;
                apply_mode = cfg_mode_in;
            end else if (pend_q) begin
                apply_div  = div_pend_q;
                apply_mode = mode_pend_q;
            end else begin
                apply_div  = div_act_q;
                apply_mode = mode_act_q;
            end

            if (sync_in) begin
                cnt_d      = '0;
                level_d    = 1'b0;
                div_act_d  = apply_div;
                mode_act_d = apply_mode;
                pend_d     = 1'b0;
            end else if (write_hit && cfg_now_in) begin
                cnt_d      = '0;
                level_d    = 1'b0;
                div_act_d  = cfg_div_in;
                mode_act_d = cfg_mode_in;
                pend_d     = 1'b0;
            end else if (en_in[gi] && (cnt_q == last_cnt)) begin
                cnt_d      = '0;
                tick_d     = 1'b1;
                div_act_d  = apply_div;
                mode_act_d = apply_mode;
                pend_d     = 1'b0;
                level_d    = apply_mode ? ~level_q : 1'b0;
            end else begin
                if (en_in[gi]) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                if (write_hit) begin
                    div_pend_d  = cfg_div_in;
                    mode_pend_d = cfg_mode_in;
                    pend_d      = 1'b1;
                end
            end
        end

        // Channel state registers with synchronous reset to the default ratio.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                cnt_q       <= '0;
                div_act_q   <= WIDTH'(DEFAULT_DIV);
                div_pend_q  <= '0;
                mode_act_q  <= 1'b0;
                mode_pend_q <= 1'b0;
                pend_q      <= 1'b0;
                level_q     <= 1'b0;
                tick_q      <= 1'b0;
            end else begin
                cnt_q       <= cnt_d;
                div_act_q   <= div_act_d;
                div_pend_q  <= div_pend_d;
                mode_act_q  <= mode_act_d;
                mode_pend_q <= mode_pend_d;
                pend_q      <= pend_d;
                level_q     <= level_d;
                tick_q      <= tick_d;
            end
        end

        assign tick_out[gi]    = tick_q;
        assign level_out[gi]   = level_q;
        assign pending_out[gi] = pend_q;
    end

endmodule
